// File: rtl/spi_ram.sv
// Command-driven byte RAM behind an SPI slave: 10-bit words carry a 2-bit opcode plus address/data.
// Define SPI_RAM_AUTOINC_EN to post-increment wr_addr after writes and rd_addr after reads.
module spi_ram #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [9:0] din,
  output logic       tx_valid,
  output logic [7:0] dout
);

  localparam int unsigned IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {IDLE, TX_HOLD} state_t;

  state_t               state, next;
  logic                 rx_valid_q;
  logic                 accept;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, din_addr;
  logic [IW-1:0]        wr_idx, rd_idx;
  logic [7:0]           mem [MEM_DEPTH];

  // Only the rising edge of rx_valid carries a command; a held-high strobe is ignored.
  assign accept   = rx_valid & ~rx_valid_q;
  assign din_addr = ADDR_SIZE'(din[7:0]);
  assign wr_idx   = IW'(32'(wr_addr) % MEM_DEPTH);
  assign rd_idx   = IW'(32'(rd_addr) % MEM_DEPTH);

`ifdef SPI_RAM_AUTOINC_EN
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [IW-1:0] idx);
    if (32'(idx) == MEM_DEPTH - 1) return '0;
    return ADDR_SIZE'(32'(idx) + 1);
  endfunction
`endif

  // Storage is never reset; writes are suppressed while rst is asserted.
  always_ff @(posedge clk) begin
    if (!rst && accept && din[9:8] == 2'b01) mem[wr_idx] <= din[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      dout       <= '0;
    end else begin
      rx_valid_q <= rx_valid;
      if (accept) begin
        case (din[9:8])
          2'b00: wr_addr <= din_addr;
          2'b01: begin
`ifdef SPI_RAM_AUTOINC_EN
            wr_addr <= next_addr(wr_idx);
`endif
          end
          2'b10: rd_addr <= din_addr;
          2'b11: begin
            dout <= mem[rd_idx];
`ifdef SPI_RAM_AUTOINC_EN
            rd_addr <= next_addr(rd_idx);
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next     = state;
    tx_valid = (state == TX_HOLD);
    if (accept) next = (din[9:8] == 2'b11) ? TX_HOLD : IDLE;
  end

endmodule

// File: tb/tb_spi_ram.sv
// Scoreboard bench for spi_ram: read commands push the model's byte, and the cycle after acceptance pops and compares.
module tb_spi_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [9:0] din = '0;
  logic       tx_valid;
  logic [7:0] dout;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [7:0] mmem [256];
  logic [7:0] mwr = '0;
  logic [7:0] mrd = '0;
  logic [7:0] exp_q [$];
  logic [7:0] expv;

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din),
    .tx_valid(tx_valid), .dout(dout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // One accepted command: strobe rises at a negedge, drops at the next; returns one cycle after acceptance.
  task automatic send(input logic [9:0] w);
    @(negedge clk);
    din = w;
    rx_valid = 1'b1;
    case (w[9:8])
      2'b00: mwr = w[7:0];
      2'b01: begin
        mmem[mwr] = w[7:0];
`ifdef SPI_RAM_AUTOINC_EN
        mwr = mwr + 8'd1;
`endif
      end
      2'b10: mrd = w[7:0];
      default: begin
        exp_q.push_back(mmem[mrd]);
`ifdef SPI_RAM_AUTOINC_EN
        mrd = mrd + 8'd1;
`endif
      end
    endcase
    @(negedge clk);
    rx_valid = 1'b0;
    din = 10'($urandom);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_state actual tv=%b dout=%h required tv=0 dout=00", tx_valid, dout);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle actual tv=%b required tv=0", tx_valid);
    end
  endtask

  // Read with no prior rd_addr load, issued while rx_valid is already high at reset release.
  task automatic test_default_rd_addr;
    send(10'h000);
    send(10'h13C);
    @(negedge clk);
    rst = 1'b1;
    din = 10'h300;
    rx_valid = 1'b1;
    mwr = '0;
    mrd = '0;
    exp_q.push_back(mmem[mrd]);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL rd_default_queue actual=empty required=entry");
    end else begin
      expv = exp_q.pop_front();
      if (tx_valid !== 1'b1 || dout !== expv || dout !== 8'h3C) begin
        failures++;
        $display("FAIL rd_default actual tv=%b dout=%h required tv=1 dout=%h", tx_valid, dout, expv);
      end
    end
  endtask

  task automatic test_write_read;
    send(10'h012);
    send(10'h1A5);
    send(10'h212);
    send(10'h300);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL write_read_queue actual=empty required=entry");
    end else begin
      expv = exp_q.pop_front();
      if (tx_valid !== 1'b1 || dout !== expv || dout !== 8'hA5) begin
        failures++;
        $display("FAIL write_read actual tv=%b dout=%h required tv=1 dout=%h", tx_valid, dout, expv);
      end
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || dout !== 8'hA5) begin
      failures++;
      $display("FAIL tx_hold_stable actual tv=%b dout=%h required tv=1 dout=a5", tx_valid, dout);
    end
  endtask

  task automatic test_tx_hold_exit;
    send(10'h000);
    checks++;
    if (tx_valid !== 1'b0 || dout !== 8'hA5) begin
      failures++;
      $display("FAIL tx_hold_exit actual tv=%b dout=%h required tv=0 dout=a5", tx_valid, dout);
    end
  endtask

  task automatic test_held_rx_valid;
    send(10'h021);
    send(10'h1C3);
    send(10'h020);
    @(negedge clk);
    din = 10'h15A;
    rx_valid = 1'b1;
    mmem[mwr] = 8'h5A;
`ifdef SPI_RAM_AUTOINC_EN
    mwr = mwr + 8'd1;
`endif
    repeat (10) @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL held_no_tx actual tv=%b required tv=0", tx_valid);
    end
    send(10'h220);
    send(10'h300);
    send(10'h221);
    send(10'h300);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL held_queue actual=empty required=entry");
      end else begin
        expv = exp_q.pop_front();
        if (i == 0 && expv !== 8'h5A || i == 1 && expv !== 8'hC3) begin
          failures++;
          $display("FAIL held_model idx=%0d actual=%h required=%h", i, expv, (i == 0) ? 8'h5A : 8'hC3);
        end
      end
    end
    // Second read is still in TX_HOLD and must show mem[0x21] untouched.
    checks++;
    if (tx_valid !== 1'b1 || dout !== 8'hC3) begin
      failures++;
      $display("FAIL held_neighbor actual tv=%b dout=%h required tv=1 dout=c3", tx_valid, dout);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r0, r1;
`ifdef SPI_RAM_AUTOINC_EN
    r0 = 8'h11;
    r1 = 8'h22;
`else
    r0 = 8'h22;
    r1 = 8'h22;
`endif
    send(10'h0FF);
    send(10'h111);
    send(10'h122);
    send(10'h2FF);
    for (int i = 0; i < 2; i++) begin
      send(10'h300);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL b2b_queue actual=empty required=entry");
      end else begin
        expv = exp_q.pop_front();
        if (tx_valid !== 1'b1 || dout !== expv || dout !== ((i == 0) ? r0 : r1)) begin
          failures++;
          $display("FAIL b2b_read idx=%0d actual tv=%b dout=%h required tv=1 dout=%h",
                   i, tx_valid, dout, (i == 0) ? r0 : r1);
        end
      end
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_continuous idx=%0d actual tv=%b required tv=1", i, tx_valid);
      end
    end
`ifdef SPI_RAM_AUTOINC_EN
    send(10'h200);
    send(10'h300);
    checks++;
    expv = exp_q.pop_front();
    if (dout !== 8'h22 || expv !== 8'h22) begin
      failures++;
      $display("FAIL autoinc_wrap_mem0 actual=%h required=22", dout);
    end
`endif
  endtask

  task automatic test_async_reset;
    checks++;
    if (tx_valid !== 1'b1 || dout === 8'h00) begin
      failures++;
      $display("FAIL async_precond actual tv=%b dout=%h required tv=1 dout!=00", tx_valid, dout);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || dout !== 8'h00) begin
      failures++;
      $display("FAIL async_reset actual tv=%b dout=%h required tv=0 dout=00", tx_valid, dout);
    end
    @(negedge clk);
    rst = 1'b0;
    mwr = '0;
    mrd = '0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_default_rd_addr;
    test_write_read;
    test_tx_hold_exit;
    test_held_rx_valid;
    test_back_to_back;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 8-bit words.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, width of internal address registers; din[7:0] zero-extended or truncated to ADDR_SIZE.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx_valid  input  1  command/data word valid from upstream SPI slave; may stay high many cycles.
REQ-006 SHALL have port din  input  10  din[9:8] command, din[7:0] address or data.
REQ-007 SHALL have port tx_valid  output  1  read data valid toward SPI slave.
REQ-008 SHALL have port dout  output  8  read data toward SPI slave.

Function
REQ-009 SHALL register rx_valid into rx_valid_q each cycle; a command is accepted only in a cycle where rx_valid=1 and rx_valid_q=0 (rising edge); a held-high rx_valid SHALL cause no further actions.
REQ-010 SHALL decode accepted din[9:8]: 00 load wr_addr; 01 write din[7:0] to mem[wr_addr]; 10 load rd_addr; 11 read mem[rd_addr].
REQ-011 SHALL perform write (01) at the acceptance clock edge; data readable by any later accepted 11.
REQ-012 SHALL implement FSM states IDLE and TX_HOLD; IDLE->TX_HOLD on accepted 11; TX_HOLD->IDLE on accepted 00/01/10; TX_HOLD->TX_HOLD on accepted 11; otherwise hold state.
REQ-013 SHALL register dout<=mem[rd_addr] at the acceptance edge of 11; dout and tx_valid=1 visible in the cycle after acceptance (latency 1).
REQ-014 SHALL keep tx_valid=1 and dout stable for the whole TX_HOLD residency; tx_valid=0 in IDLE.
REQ-015 SHALL on accepted 00/01/10 in TX_HOLD drop tx_valid in the following cycle; dout holds its last value.
REQ-016 SHALL on back-to-back 11 commands keep tx_valid=1 continuously, dout updating to the new word the cycle after each acceptance.
REQ-017 SHALL execute 11 with current rd_addr even if no 10 was accepted since reset (rd_addr=0).
REQ-018 SHALL ignore din whenever no command is accepted; addresses outside MEM_DEPTH SHALL wrap modulo MEM_DEPTH.
REQ-019 SHALL NOT reset memory array contents.

Reset
REQ-020 SHALL, while rst=1, asynchronously force tx_valid=0, dout=8'h00, wr_addr=0, rd_addr=0, rx_valid_q=0, state=IDLE.
REQ-021 SHALL, on rst assertion mid-TX_HOLD or mid-write-cycle, abandon the operation; a write coincident with reset assertion SHALL not be guaranteed.
REQ-022 SHALL, after rst release with rx_valid already high, accept a command on the first clk edge (rx_valid_q=0).

Configuration
REQ-023 SHALL support macro SPI_RAM_AUTOINC_EN.
REQ-024 With SPI_RAM_AUTOINC_EN defined: after each accepted 01, wr_addr increments by 1; after each accepted 11, rd_addr increments by 1 (after the read); MEM_DEPTH-1 wraps to 0.
REQ-025 Without SPI_RAM_AUTOINC_EN: wr_addr and rd_addr change only on 00/10 or reset.

Verification
REQ-026 Reset: rst=1 asynchronously mid-cycle -> tx_valid=0, dout=8'h00 immediately, before next clk edge.
REQ-027 Write/read: accept 0x0_12 (wr_addr 0x12), 0x1_A5, 0x2_12, 0x3_00 -> one cycle after last acceptance tx_valid=1, dout=8'hA5.
REQ-028 Held rx_valid: din=0x1_5A with rx_valid high 10 cycles, wr_addr=0x20 -> exactly one write; mem[0x20]=8'h5A, mem[0x21] unchanged (with autoinc enabled).
REQ-029 TX_HOLD exit: after read returns 8'hA5, accept 0x0_00 -> tx_valid=0 next cycle, dout stays 8'hA5.
REQ-030 Autoinc (SPI_RAM_AUTOINC_EN): wr_addr=0xFF, write 0x11 then 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22; rd_addr=0xFF, two 11 reads -> dout 0x11 then 0x22, tx_valid continuously 1.
REQ-031 No autoinc: same stimulus as REQ-030 -> mem[0xFF]=0x22, both reads return 0x22.
